// File: rtl/spi_slave_frame.sv
// -----------------------------------------------------------------------------
// spi_slave_frame
//
// Fixed-length SPI slave. SCK, SSEL and MOSI come from an external master and
// are asynchronous to clk. All three are oversampled through synchroniser
// chains, and all SPI activity is decoded in the clk domain. A frame is the
// interval during which SSEL is low. It is accepted only if exactly FRAME_BITS
// bits were sampled during that interval.
//
// Parameters
//   FRAME_BITS : MOSI bits in a good frame (8..256)
//   TX_BITS    : MISO payload width (1..FRAME_BITS)
//   CPOL       : SCK idle level
//   CPHA       : 0 = sample on the leading edge, 1 = sample on the trailing edge
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active high
//   SCK        : SPI clock from the master (asynchronous)
//   SSEL       : SPI select, active low (asynchronous)
//   MOSI       : master-out serial data, MSB first
//   MISO       : slave-out serial data, MSB first; 0 while not selected
//   tx_data    : payload to send; captured when the frame starts
//   tx_valid   : tx_data is fresh
//   tx_ack     : one-clk pulse in the cycle tx_data is captured
//   rx_data    : last good frame; the first bit received is in the MSB
//   rx_valid   : one-clk pulse when rx_data updates
//   frame_err  : one-clk pulse when a frame ends with the wrong bit count
//   busy       : synchronised SSEL is active
//   LED        : toggles on every good frame
// -----------------------------------------------------------------------------
module spi_slave_frame #(
    parameter int FRAME_BITS = 88,
    parameter int TX_BITS    = 40,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SCK,
    input  logic                  SSEL,
    input  logic                  MOSI,
    output logic                  MISO,
    input  logic [TX_BITS-1:0]    tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ack,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  busy,
    output logic                  LED
);

    // The counter must be able to hold FRAME_BITS+1, which is its saturation value.
    localparam int              CNT_W    = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    // Synchroniser chains. Stage 0 is the metastability catcher. Edges are
    // decoded from stages [2:1].
    logic [2:0]            r_sck_sync;
    logic [2:0]            r_ssel_sync;
    logic [1:0]            r_mosi_sync;

    logic [CNT_W-1:0]      r_count;
    logic [FRAME_BITS-1:0] r_rx_shift;
    logic [TX_BITS-1:0]    r_tx_shift;
    logic                  r_first_lead;

    logic [FRAME_BITS-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic                  r_frame_err;
    logic                  r_led;

    logic w_sck_rise;
    logic w_sck_fall;
    logic w_lead;
    logic w_trail;
    logic w_ssel_start;
    logic w_ssel_end;
    logic w_busy;
    logic w_edge_ok;
    logic w_sample;
    logic w_shift;

    // -------------------------------------------------------------------------
    // Input synchronisers
    // -------------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments so that all
    // stages update from their pre-edge values. Blocking assignments here
    // would collapse the shift chain into a single flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sck_sync  <= {3{CPOL}};
            r_ssel_sync <= 3'b111;
            r_mosi_sync <= 2'b00;
        end else begin
            r_sck_sync  <= {r_sck_sync[1:0], SCK};
            r_ssel_sync <= {r_ssel_sync[1:0], SSEL};
            r_mosi_sync <= {r_mosi_sync[0], MOSI};
        end
    end

    // -------------------------------------------------------------------------
    // Edge decode
    // -------------------------------------------------------------------------
    assign w_sck_rise   = (r_sck_sync[2:1] == 2'b01);
    assign w_sck_fall   = (r_sck_sync[2:1] == 2'b10);
    assign w_lead       = CPOL ? w_sck_fall : w_sck_rise;
    assign w_trail      = CPOL ? w_sck_rise : w_sck_fall;

    assign w_ssel_start = (r_ssel_sync[2:1] == 2'b10);
    assign w_ssel_end   = (r_ssel_sync[2:1] == 2'b01);
    assign w_busy       = ~r_ssel_sync[1];

    // When a frame starts, the register load wins and any coincident SCK edge
    // is dropped. An edge that coincides with the frame end is already outside
    // busy, so it is dropped as well.
    assign w_edge_ok    = w_busy & ~w_ssel_start;
    assign w_sample     = w_edge_ok & (CPHA ? w_trail : w_lead);

    // With CPHA=1 the first leading edge only tells the master to start
    // sampling. The MSB is already on MISO, so that edge must not shift it away.
    assign w_shift      = w_edge_ok & (CPHA ? (w_lead & ~r_first_lead) : w_trail);

    // -------------------------------------------------------------------------
    // Frame datapath: bit counter, rx and tx shift registers
    // -------------------------------------------------------------------------
    // NOTE: the shift registers are reset along with the control state. A reset
    // in the middle of a frame must leave MISO at 0 and must not let a partial
    // frame leak into rx_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count      <= '0;
            r_rx_shift   <= '0;
            r_tx_shift   <= '0;
            r_first_lead <= 1'b0;
        end else if (w_ssel_start) begin
            r_count      <= '0;
            r_tx_shift   <= tx_valid ? tx_data : '0;
            r_first_lead <= 1'b1;
        end else begin
            if (w_sample) begin
                r_rx_shift <= {r_rx_shift[FRAME_BITS-2:0], r_mosi_sync[1]};
                if (r_count != CNT_SAT) begin
                    r_count <= r_count + 1'b1;
                end
            end

            // Zero the leftover payload at the frame end so that MISO starts
            // clean in the next frame.
            if (w_ssel_end) begin
                r_tx_shift <= '0;
            end else if (w_shift) begin
                r_tx_shift <= r_tx_shift << 1;
            end

            if (w_edge_ok && w_lead) begin
                r_first_lead <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Frame completion
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_led       <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_ssel_end) begin
                if (r_count == CNT_FULL) begin
                    r_rx_data  <= r_rx_shift;
                    r_rx_valid <= 1'b1;
                    r_led      <= ~r_led;
                end else begin
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign MISO      = w_busy & r_tx_shift[TX_BITS-1];
    assign tx_ack    = w_ssel_start & tx_valid;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign busy      = w_busy;
    assign LED       = r_led;

endmodule

// File: doc/spi_slave_frame.md
SPI_SLAVE_FRAME -- requirements
Module: spi_slave_frame

Interface
REQ-001 Parameter FRAME_BITS, default 88, number of MOSI bits in a valid frame (range 8..256).
REQ-002 Parameter TX_BITS, default 40, width of the MISO payload (range 1..FRAME_BITS).
REQ-003 Parameter CPOL, default 0, SCK idle level.
REQ-004 Parameter CPHA, default 0, where 0 = sample on leading edge and 1 = sample on trailing edge.
REQ-005 clk  input  1  system clock; all logic is on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 SCK  input  1  SPI clock from master, asynchronous to clk.
REQ-008 SSEL  input  1  SPI select, active low, asynchronous.
REQ-009 MOSI  input  1  master-out serial data, MSB first.
REQ-010 MISO  output  1  slave-out serial data, MSB first.
REQ-011 tx_data  input  TX_BITS  payload to send, sampled at frame start.
REQ-012 tx_valid  input  1  tx_data holds fresh data.
REQ-013 tx_ack  output  1  one-clk pulse when tx_data was captured.
REQ-014 rx_data  output  FRAME_BITS  last good received frame; first bit received is at rx_data[FRAME_BITS-1].
REQ-015 rx_valid  output  1  one-clk pulse when rx_data updates.
REQ-016 frame_err  output  1  one-clk pulse when a frame ends with bit count not equal to FRAME_BITS.
REQ-017 busy  output  1  synchronised SSEL is active.
REQ-018 LED  output  1  toggles on every good frame.

Function
REQ-019 SCK and SSEL SHALL each pass a 3-FF shift register; edges are decoded from stages [2:1]. MOSI SHALL pass a 2-FF register and is used from stage [1].
REQ-020 Leading edge is rising when CPOL=0 and falling when CPOL=1; trailing edge is the opposite; the sample edge is selected by CPHA.
REQ-021 SSEL start is the synchronised 1->0 transition; SSEL end is the synchronised 0->1 transition; busy is the inverse of SSEL stage [1].
REQ-022 Each sample edge while busy SHALL shift MOSI into the rx shift register LSB-first-in, and increment the bit counter.
REQ-023 The bit counter SHALL saturate at FRAME_BITS+1 and never wrap.
REQ-024 At SSEL start, the bit counter SHALL clear.
- If tx_valid=1: tx shift register loads tx_data and tx_ack pulses in the same cycle.
- Otherwise: the tx shift register loads all zeros.
REQ-025 For CPHA=0, the tx shift register SHALL shift left by one on each trailing edge while busy.
REQ-026 For CPHA=1, the tx shift register SHALL shift left on each leading edge except the first leading edge of the frame.
REQ-027 MISO SHALL equal the tx shift register MSB; zeros shift in, so MISO=0 once TX_BITS bits have been sent; MISO=0 while not busy.
REQ-028 On the clk after SSEL end is detected:
- If count==FRAME_BITS: rx_data loads the rx shift register, rx_valid pulses and LED toggles.
- Otherwise: frame_err pulses and rx_data holds its previous value.
REQ-029 A sample edge coinciding with SSEL end SHALL be ignored.
REQ-030 An SSEL start coinciding with an SCK edge SHALL take priority: the register load occurs and the edge is ignored.
REQ-031 SSEL end with zero bits (select glitch) SHALL raise frame_err.
REQ-032 Correct operation requires SCK high and low phases of at least 3 clk periods each, and SSEL high of at least 3 clk periods between frames.

Reset
REQ-033 While rst=1, all outputs SHALL be 0, except LED=0 and MISO=0.
REQ-034 While rst=1, counters and shift registers SHALL be 0, SSEL sync stages SHALL be 1, and SCK sync stages SHALL equal CPOL.
REQ-035 Reset asserted mid-frame SHALL abort the frame with no rx_valid and no frame_err.
REQ-036 If SSEL is low at reset release, a new frame start SHALL be recognised 2 clk after release.

Verification
REQ-037 Mode 0, defaults, tx_valid=1, tx_data=40'hA5_5A_0F_F0_C3, master sends 88 bits of 88'h0123456789ABCDEF012345 -> tx_ack pulse at start; MISO carries A55A0FF0C3 then 48 zeros; rx_valid is one pulse; rx_data=88'h0123456789ABCDEF012345; LED=1.
REQ-038 Frame of 87 bits, then a frame of 89 bits -> two frame_err pulses; no rx_valid; rx_data unchanged.
REQ-039 CPOL=1, CPHA=1, FRAME_BITS=16, TX_BITS=16, tx_data=16'hBEEF, MOSI=16'h1234 -> MISO captured on the master sample edge is BEEF; rx_data=16'h1234.
REQ-040 tx_valid=0 at frame start -> no tx_ack; MISO=0 for the entire frame.
REQ-041 rst pulsed after 40 bits of a frame, SSEL held low, then 88 more bits clocked -> no pulse during the aborted frame; the new frame starts 2 clk after release; rx_valid with the last 88 bits.
REQ-042 SSEL low for 5 clk with no SCK -> frame_err pulse; busy high for the synchronised window only.
